// File: rtl/sd_block_read.sv
// sd_block_read: CMD17 single-block read sequencer in front of the SD SPI byte engine.
// Ports: clock/reset (sync, active-high); start/lba request; busy/done/error/err_code status;
//   rd_data/rd_we/rd_addr sector byte stream; sd_signal/sd_cmd/sd_out to the engine,
//   sd_din/sd_busy from the engine.
module sd_block_read #(
  parameter bit BYTE_ADDR  = 1'b0,
  parameter int R1_POLL    = 8,
  parameter int TOKEN_POLL = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] lba,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [7:0]  rd_data,
  output logic        rd_we,
  output logic [8:0]  rd_addr,
  output logic        sd_signal,
  output logic [1:0]  sd_cmd,
  output logic [7:0]  sd_out,
  input  logic [7:0]  sd_din,
  input  logic        sd_busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_CSLO, S_PRE, S_CMD, S_R1,
    S_TOK, S_DATA, S_CRC, S_CSHI, S_TAIL
  } state_t;

  // Every engine operation walks issue -> one skipped cycle -> wait for idle.
  typedef enum logic [1:0] {
    P_ISSUE, P_WAIT1, P_WAITB
  } phase_t;

  localparam logic [1:0] C_XFER = 2'd1;
  localparam logic [1:0] C_CSLO = 2'd2;
  localparam logic [1:0] C_CSHI = 2'd3;

  localparam logic [15:0] R1_LAST  = 16'(R1_POLL - 1);
  localparam logic [15:0] TOK_LAST = 16'(TOKEN_POLL - 1);

  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic [15:0] cnt, cnt_n;
  logic [31:0] arg, arg_n;
  logic [1:0]  err_n;
  logic        done_n, error_n, rd_we_n;
  logic [7:0]  rd_data_n;
  logic [8:0]  rd_addr_n;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      phase    <= P_ISSUE;
      cnt      <= '0;
      arg      <= '0;
      err_code <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      rd_we    <= 1'b0;
      rd_data  <= '0;
      rd_addr  <= '0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      cnt      <= cnt_n;
      arg      <= arg_n;
      err_code <= err_n;
      done     <= done_n;
      error    <= error_n;
      rd_we    <= rd_we_n;
      rd_data  <= rd_data_n;
      rd_addr  <= rd_addr_n;
    end
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    cnt_n     = cnt;
    arg_n     = arg;
    err_n     = err_code;
    done_n    = 1'b0;
    error_n   = 1'b0;
    rd_we_n   = 1'b0;
    rd_data_n = rd_data;
    rd_addr_n = rd_addr;
    sd_signal = 1'b0;
    sd_cmd    = 2'd0;
    sd_out    = 8'hFF;

    if (state == S_IDLE) begin
      if (start && !sd_busy) begin
        state_n = S_CSLO;
        phase_n = P_ISSUE;
        cnt_n   = '0;
        err_n   = 2'd0;
        arg_n   = BYTE_ADDR ? {lba[22:0], 9'd0} : lba;
      end
    end else begin
      unique case (phase)
        P_ISSUE: begin
          sd_signal = 1'b1;
          phase_n   = P_WAIT1;
          unique case (1'b1)
            state == S_CSLO: sd_cmd = C_CSLO;
            state == S_CSHI: sd_cmd = C_CSHI;
            default:         sd_cmd = C_XFER;
          endcase
          if (state == S_CMD) begin
            case (cnt[2:0])
              3'd0:    sd_out = 8'h51;
              3'd1:    sd_out = arg[31:24];
              3'd2:    sd_out = arg[23:16];
              3'd3:    sd_out = arg[15:8];
              3'd4:    sd_out = arg[7:0];
              default: sd_out = 8'hFF;
            endcase
          end
        end
        P_WAIT1: phase_n = P_WAITB;
        P_WAITB: begin
          if (!sd_busy) begin
            phase_n = P_ISSUE;
            unique case (state)
              S_CSLO: state_n = S_PRE;
              S_PRE: begin
                state_n = S_CMD;
                cnt_n   = '0;
              end
              S_CMD: begin
                if (cnt == 16'd5) begin
                  state_n = S_R1;
                  cnt_n   = '0;
                end else begin
                  cnt_n = cnt + 16'd1;
                end
              end
              S_R1: begin
                if (!sd_din[7]) begin
                  if (sd_din == 8'h00) begin
                    state_n = S_TOK;
                    cnt_n   = '0;
                  end else begin
                    err_n   = 2'd1;
                    state_n = S_CSHI;
                  end
                end else if (cnt == R1_LAST) begin
                  err_n   = 2'd2;
                  state_n = S_CSHI;
                end else begin
                  cnt_n = cnt + 16'd1;
                end
              end
              S_TOK: begin
                if (sd_din == 8'hFE) begin
                  state_n = S_DATA;
                  cnt_n   = '0;
                end else if (sd_din == 8'hFF &&
                             cnt != TOK_LAST) begin
                  cnt_n = cnt + 16'd1;
                end else begin
                  err_n   = 2'd3;
                  state_n = S_CSHI;
                end
              end
              S_DATA: begin
                rd_we_n   = 1'b1;
                rd_data_n = sd_din;
                rd_addr_n = cnt[8:0];
                if (cnt == 16'd511) begin
                  state_n = S_CRC;
                  cnt_n   = '0;
                end else begin
                  cnt_n = cnt + 16'd1;
                end
              end
              S_CRC: begin
                if (cnt == 16'd1) begin
                  state_n = S_CSHI;
                end else begin
                  cnt_n = cnt + 16'd1;
                end
              end
              S_CSHI: state_n = S_TAIL;
              S_TAIL: begin
                state_n = S_IDLE;
                done_n  = (err_code == 2'd0);
                error_n = (err_code != 2'd0);
              end
              default: state_n = S_IDLE;
            endcase
          end
        end
        default: phase_n = P_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_read.sv
// tb_sd_block_read: byte-level SD engine + card model around two sd_block_read
// instances (block and byte addressing), scoreboarded sector data.
module tb_sd_block_read;

  localparam int ENG_LAT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] lba = '0;
  logic        sel = 1'b0;
  logic        sd_busy = 1'b0;
  logic [7:0]  sd_din = 8'hFF;

  logic       b0, d0, e0, we0, sg0;
  logic [1:0] ec0, cm0;
  logic [7:0] rdd0, so0;
  logic [8:0] ra0;
  logic       b1, d1, e1, we1, sg1;
  logic [1:0] ec1, cm1;
  logic [7:0] rdd1, so1;
  logic [8:0] ra1;
  logic       st0, st1;

  assign st0 = start & ~sel;
  assign st1 = start & sel;

  always #20 clk = ~clk;

  sd_block_read #(.BYTE_ADDR(1'b0)) u0 (
    .clock(clk), .reset(reset), .start(st0), .lba(lba),
    .busy(b0), .done(d0), .error(e0), .err_code(ec0),
    .rd_data(rdd0), .rd_we(we0), .rd_addr(ra0),
    .sd_signal(sg0), .sd_cmd(cm0), .sd_out(so0),
    .sd_din(sd_din), .sd_busy(sd_busy)
  );

  sd_block_read #(.BYTE_ADDR(1'b1)) u1 (
    .clock(clk), .reset(reset), .start(st1), .lba(lba),
    .busy(b1), .done(d1), .error(e1), .err_code(ec1),
    .rd_data(rdd1), .rd_we(we1), .rd_addr(ra1),
    .sd_signal(sg1), .sd_cmd(cm1), .sd_out(so1),
    .sd_din(sd_din), .sd_busy(sd_busy)
  );

  logic       m_busy, m_done, m_error, m_we, m_sig;
  logic [1:0] m_ec, m_cmd;
  logic [7:0] m_rdd, m_out;
  logic [8:0] m_ra;
  logic [33:0] rv0, rv1;

  assign m_busy  = sel ? b1 : b0;
  assign m_done  = sel ? d1 : d0;
  assign m_error = sel ? e1 : e0;
  assign m_we    = sel ? we1 : we0;
  assign m_sig   = sel ? sg1 : sg0;
  assign m_ec    = sel ? ec1 : ec0;
  assign m_cmd   = sel ? cm1 : cm0;
  assign m_rdd   = sel ? rdd1 : rdd0;
  assign m_out   = sel ? so1 : so0;
  assign m_ra    = sel ? ra1 : ra0;
  assign rv0 = {b0, d0, e0, ec0, we0, ra0, rdd0, sg0, cm0, so0};
  assign rv1 = {b1, d1, e1, ec1, we1, ra1, rdd1, sg1, cm1, so1};

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // card configuration
  int         r1_delay = 2;
  logic [7:0] r1_val = 8'h00;
  bit         r1_never = 1'b0;
  int         tok_delay = 100;

  // card / engine state
  logic       cs = 1'b1;
  int         fidx = 0;
  int         resp_n = 0;
  int         resp_at_cs = 0;
  logic [7:0] frame [6];
  logic [7:0] eng_resp = 8'hFF;
  int         eng_cnt = 0;
  logic       overlap = 1'b0;
  logic       bad_cmd = 1'b0;

  function automatic logic [7:0] card_byte(input int k);
    int t, d;
    if (r1_never) return 8'hFF;
    if (k < r1_delay) return 8'hFF;
    if (k == r1_delay) return r1_val;
    if (r1_val != 8'h00) return 8'hFF;
    t = k - r1_delay - 1;
    if (t < tok_delay) return 8'hFF;
    if (t == tok_delay) return 8'hFE;
    d = t - tok_delay - 1;
    if (d < 512) return 8'(d) ^ 8'hA5;
    return 8'hFF;
  endfunction

  always @(posedge clk) begin
    if (m_sig) begin
      if (sd_busy) overlap <= 1'b1;
      eng_cnt <= ENG_LAT;
      sd_busy <= 1'b1;
      case (m_cmd)
        2'd2: begin
          cs <= 1'b0;
          fidx <= 0;
          resp_n <= 0;
          eng_resp <= 8'hFF;
        end
        2'd3: begin
          cs <= 1'b1;
          resp_at_cs <= resp_n;
          eng_resp <= 8'hFF;
        end
        2'd1: begin
          if (!cs && fidx < 6 && (fidx != 0 || m_out == 8'h51)) begin
            frame[fidx] <= m_out;
            fidx <= fidx + 1;
            eng_resp <= 8'hFF;
          end else if (!cs && fidx == 6) begin
            eng_resp <= card_byte(resp_n);
            resp_n <= resp_n + 1;
          end else begin
            eng_resp <= 8'hFF;
          end
        end
        default: begin
          bad_cmd <= 1'b1;
          eng_resp <= 8'hFF;
        end
      endcase
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        sd_busy <= 1'b0;
        sd_din <= eng_resp;
      end
    end
  end

  // scoreboard / monitor
  logic [16:0] sbq [$];
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   rd_cnt = 0;
  logic prev_busy = 1'b0;
  logic hit200 = 1'b0;

  always @(negedge clk) begin
    if (!reset && m_we) begin
      rd_cnt++;
      if (m_ra == 9'd200) hit200 = 1'b1;
      if (sbq.size() == 0) begin
        chk("rd_extra", 1, 0);
      end else begin
        chk("rd_byte", {m_ra, m_rdd}, sbq.pop_front());
      end
    end
    if (!reset && (m_done || m_error))
      chk("busy_fall", {prev_busy, m_busy}, 2'b10);
    if (!reset && m_done) done_cnt++;
    if (!reset && m_error) err_cnt++;
    prev_busy = m_busy;
  end

  task automatic push_data();
    sbq.delete();
    for (int i = 0; i < 512; i++)
      sbq.push_back({9'(i), 8'(i) ^ 8'hA5});
  endtask

  task automatic pulse_start(input logic [31:0] a);
    @(negedge clk);
    start = 1'b1;
    lba = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int ev0;
    int n;
    ev0 = done_cnt + err_cnt;
    n = 0;
    while (done_cnt + err_cnt == ev0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) chk("timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [47:0] frame_v();
    return {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5]};
  endfunction

  int dc, ec, rc;
  logic got, sbacc;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_u0", rv0, 34'hFF);
    chk("rst_u1", rv1, 34'hFF);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // normal read, with stray starts while busy
    push_data();
    dc = done_cnt; ec = err_cnt; rc = rd_cnt;
    pulse_start(32'h0000_1234);
    fork
      wait_end(20000);
      begin
        repeat (200) @(negedge clk);
        pulse_start(32'h0000_0077);
        repeat (1500) @(negedge clk);
        pulse_start(32'h0000_0088);
      end
    join
    chk("n_frame", frame_v(), 48'h51_00_00_12_34_FF);
    chk("n_done", done_cnt - dc, 1);
    chk("n_err", err_cnt - ec, 0);
    chk("n_rdcnt", rd_cnt - rc, 512);
    chk("n_sbq", sbq.size(), 0);
    chk("n_cs", cs, 1);
    chk("n_bytes", resp_at_cs, 618);
    repeat (10) @(negedge clk);
    chk("n_norestart", m_busy, 0);

    // byte-addressed card
    sel = 1'b1;
    push_data();
    dc = done_cnt; rc = rd_cnt;
    pulse_start(32'h0000_0001);
    wait_end(20000);
    chk("b_frame", frame_v(), 48'h51_00_00_02_00_FF);
    chk("b_done", done_cnt - dc, 1);
    chk("b_rdcnt", rd_cnt - rc, 512);
    chk("b_ec", m_ec, 0);
    sel = 1'b0;
    @(negedge clk);

    // R1 error
    sbq.delete();
    r1_val = 8'h05;
    dc = done_cnt; ec = err_cnt; rc = rd_cnt;
    pulse_start(32'h0000_0042);
    wait_end(5000);
    chk("r1_err", err_cnt - ec, 1);
    chk("r1_done", done_cnt - dc, 0);
    chk("r1_ec", m_ec, 1);
    chk("r1_rd", rd_cnt - rc, 0);
    chk("r1_cs", cs, 1);

    // R1 timeout
    r1_val = 8'h00;
    r1_never = 1'b1;
    ec = err_cnt; rc = rd_cnt;
    pulse_start(32'h0000_0043);
    wait_end(5000);
    chk("r1t_err", err_cnt - ec, 1);
    chk("r1t_ec", m_ec, 2);
    chk("r1t_bytes", resp_at_cs, 8);
    chk("r1t_cs", cs, 1);

    // token timeout
    r1_never = 1'b0;
    tok_delay = 100000;
    ec = err_cnt; rc = rd_cnt;
    pulse_start(32'h0000_0044);
    wait_end(60000);
    chk("tok_err", err_cnt - ec, 1);
    chk("tok_ec", m_ec, 3);
    chk("tok_bytes", resp_at_cs, 2 + 1 + 4096);
    chk("tok_rd", rd_cnt - rc, 0);
    chk("tok_cs", cs, 1);
    repeat (3) @(negedge clk);
    chk("tok_ec_hold", m_ec, 3);

    // reset in the middle of the data phase
    tok_delay = 100;
    push_data();
    hit200 = 1'b0;
    pulse_start(32'h0000_0055);
    for (int i = 0; i < 20000 && !hit200; i++) @(posedge clk);
    chk("mid_hit200", hit200, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst", rv0, 34'hFF);
    reset = 1'b0;
    push_data();
    dc = done_cnt; rc = rd_cnt;
    start = 1'b1;
    lba = 32'h0000_1234;
    got = 1'b0;
    sbacc = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      sbacc = sd_busy;
      @(negedge clk);
      if (m_busy) got = 1'b1;
    end
    start = 1'b0;
    chk("mid_accept", got, 1);
    chk("mid_wait_idle", sbacc, 0);
    wait_end(20000);
    chk("mid_done", done_cnt - dc, 1);
    chk("mid_rdcnt", rd_cnt - rc, 512);
    chk("mid_frame", frame_v(), 48'h51_00_00_12_34_FF);
    chk("mid_cs", cs, 1);

    chk("sig_while_busy", overlap, 0);
    chk("cmd0_issued", bad_cmd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
